// File: rtl/block_loader.sv
// block_loader
//   Byte-stream command loader. Parses framed commands from a valid/ready
//   byte stream and issues one-cycle write strobes into the instruction
//   memory and the two register memories. It also keeps the count of active
//   blocks that is handed to the fetch stage.
//
//   Commands (opcode byte first, multi-byte values MSB first):
//     0x01 addr i3 i2 i1 i0     write 32-bit instruction word
//     0x02 addr v..             write register-0 value (data_width/8 bytes)
//     0x03 addr v..             write register-1 value (data_width/8 bytes)
//     0x04 count                set n_blocks_running (saturating)
//     0x05                      halt: n_blocks_running = 0
//     other                     discarded, cmd_error pulse
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready/in_byte  command byte stream handshake
//   instr_write_*              instruction memory write port
//   reg_write_addr/val         shared register memory write address/value
//   reg_0/1_write_enable       per-register-memory write strobes
//   n_blocks_running           active block count for the fetch stage
//   cmd_done, cmd_error        one-cycle completion / bad-opcode pulses
//
// State table
//   state    | meaning
//   IDLE     | waiting for an opcode byte
//   ADDR     | capturing the address byte (or count byte for 0x04)
//   DATA     | shifting value bytes in, counting them
//   WRITE    | strobe cycle; input stalled, then back to IDLE
module block_loader #(
  parameter int data_width = 16,
  parameter int n_blocks   = 256,
  localparam int AW        = $clog2(n_blocks)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_byte,
  output logic [AW-1:0]         instr_write_addr,
  output logic [31:0]           instr_write_val,
  output logic                  instr_write_enable,
  output logic [AW-1:0]         reg_write_addr,
  output logic [data_width-1:0] reg_write_val,
  output logic                  reg_0_write_enable,
  output logic                  reg_1_write_enable,
  output logic [AW-1:0]         n_blocks_running,
  output logic                  cmd_done,
  output logic                  cmd_error
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  localparam logic [2:0] OP_INSTR = 3'd1;
  localparam logic [2:0] OP_REG0  = 3'd2;
  localparam logic [2:0] OP_REG1  = 3'd3;
  localparam logic [2:0] OP_COUNT = 3'd4;

  localparam logic [1:0]    REG_LAST = 2'(data_width / 8 - 1);
  localparam logic [AW-1:0] NB_MAX   = AW'(n_blocks - 1);

  logic [1:0]    state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   shift_q, shift_d;
  logic [AW-1:0] nbr_q, nbr_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          accept;
  logic [1:0]    last_cnt;

  assign in_ready = (state_q != ST_WRITE);
  assign accept   = in_valid & in_ready;
  assign last_cnt = (op_q == OP_INSTR) ? 2'd3 : REG_LAST;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    nbr_d   = nbr_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (in_byte)
            8'h01, 8'h02, 8'h03, 8'h04: begin
              op_d    = in_byte[2:0];
              cnt_d   = 2'd0;
              state_d = ST_ADDR;
            end
            8'h05: begin
              nbr_d  = '0;
              done_d = 1'b1;
            end
            default: error_d = 1'b1;
          endcase
        end
      end
      ST_ADDR: begin
        if (accept) begin
          if (op_q == OP_COUNT) begin
            // The count output is only AW bits wide, so n_blocks itself is
            // not representable; anything at or above it clamps to the top.
            nbr_d   = ({24'd0, in_byte} >= 32'(n_blocks)) ? NB_MAX : in_byte[AW-1:0];
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            addr_d  = in_byte[AW-1:0];
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          shift_d = {shift_q[23:0], in_byte};
          if (cnt_q == last_cnt) begin
            done_d  = 1'b1;
            state_d = ST_WRITE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= 3'd0;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      shift_q <= 32'd0;
      nbr_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      nbr_q   <= nbr_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Pulses are masked by reset so a reset landing on the WRITE cycle
  // cancels the write rather than letting it through.
  assign instr_write_enable = (state_q == ST_WRITE) && (op_q == OP_INSTR) && !reset;
  assign reg_0_write_enable = (state_q == ST_WRITE) && (op_q == OP_REG0) && !reset;
  assign reg_1_write_enable = (state_q == ST_WRITE) && (op_q == OP_REG1) && !reset;
  assign cmd_done           = done_q & ~reset;
  assign cmd_error          = error_q & ~reset;

  assign instr_write_addr = addr_q;
  assign reg_write_addr   = addr_q;
  assign instr_write_val  = shift_q;
  assign reg_write_val    = shift_q[data_width-1:0];
  assign n_blocks_running = nbr_q;

endmodule

// File: tb/tb_block_loader.sv
// tb_block_loader
//   Directed byte streams into two loaders (n_blocks = 256 and 16) sharing
//   one stimulus bus. A frame-level model predicts every output each cycle;
//   literal checks at key points pin the model to hand-computed values.
module tb_block_loader;
  localparam int DW   = 16;
  localparam int NB   = 256;
  localparam int NB16 = 16;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic [7:0] in_byte;

  logic        in_ready, iwe, r0we, r1we, done, err;
  logic [7:0]  iaddr, raddr, nbr;
  logic [31:0] ival;
  logic [15:0] rval;

  logic        rdy16, iwe16, r0we16, r1we16, done16, err16;
  logic [3:0]  iaddr16, raddr16, nbr16;
  logic [31:0] ival16;
  logic [15:0] rval16;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  block_loader #(.data_width(DW), .n_blocks(NB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .instr_write_addr(iaddr), .instr_write_val(ival), .instr_write_enable(iwe),
    .reg_write_addr(raddr), .reg_write_val(rval),
    .reg_0_write_enable(r0we), .reg_1_write_enable(r1we),
    .n_blocks_running(nbr), .cmd_done(done), .cmd_error(err)
  );

  block_loader #(.data_width(DW), .n_blocks(NB16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy16), .in_byte(in_byte),
    .instr_write_addr(iaddr16), .instr_write_val(ival16), .instr_write_enable(iwe16),
    .reg_write_addr(raddr16), .reg_write_val(rval16),
    .reg_0_write_enable(r0we16), .reg_1_write_enable(r1we16),
    .n_blocks_running(nbr16), .cmd_done(done16), .cmd_error(err16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Frame-level model: collects accepted bytes and acts once a frame is whole.
  int          frame[$];
  bit          m_valid = 1'b0;
  logic        m_ready, m_iwe, m_r0, m_r1, m_done, m_err;
  int          m_addr, m_nbr, m_nbr16;
  logic [31:0] m_val;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      frame.delete();
      m_ready = 1'b1;
      {m_iwe, m_r0, m_r1, m_done, m_err} = '0;
      m_nbr = 0; m_nbr16 = 0; m_addr = 0; m_val = 0;
      m_valid = 1'b1;
    end else begin
      {m_iwe, m_r0, m_r1, m_done, m_err} = '0;
      if (!m_ready) begin
        m_ready = 1'b1;
      end else if (in_valid) begin
        frame.push_back(int'(in_byte));
        case (frame[0])
          1, 2, 3: begin
            if (frame.size() == ((frame[0] == 1) ? 6 : 2 + DW / 8)) begin
              m_addr = frame[1];
              m_val = 0;
              for (int i = 2; i < frame.size(); i++) m_val = (m_val << 8) | 32'(frame[i]);
              m_iwe = (frame[0] == 1);
              m_r0  = (frame[0] == 2);
              m_r1  = (frame[0] == 3);
              m_done = 1'b1;
              m_ready = 1'b0;
              frame.delete();
            end
          end
          4: begin
            if (frame.size() == 2) begin
              m_nbr   = (frame[1] >= NB)   ? NB - 1   : frame[1];
              m_nbr16 = (frame[1] >= NB16) ? NB16 - 1 : frame[1];
              m_done = 1'b1;
              frame.delete();
            end
          end
          5: begin
            m_nbr = 0; m_nbr16 = 0;
            m_done = 1'b1;
            frame.delete();
          end
          default: begin
            m_err = 1'b1;
            frame.delete();
          end
        endcase
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("in_ready",   in_ready, m_ready);
      chk("instr_we",   iwe,  m_iwe  & ~reset);
      chk("reg0_we",    r0we, m_r0   & ~reset);
      chk("reg1_we",    r1we, m_r1   & ~reset);
      chk("cmd_done",   done, m_done & ~reset);
      chk("cmd_error",  err,  m_err  & ~reset);
      chk("nbr",        nbr,  m_nbr);
      chk("in_ready16", rdy16,  m_ready);
      chk("instr_we16", iwe16,  m_iwe  & ~reset);
      chk("reg0_we16",  r0we16, m_r0   & ~reset);
      chk("reg1_we16",  r1we16, m_r1   & ~reset);
      chk("cmd_done16", done16, m_done & ~reset);
      chk("cmd_error16", err16, m_err  & ~reset);
      chk("nbr16",      nbr16,  m_nbr16);
      if (m_iwe && !reset) begin
        chk("instr_addr",   iaddr,   m_addr % NB);
        chk("instr_val",    ival,    m_val);
        chk("instr_addr16", iaddr16, m_addr % NB16);
        chk("instr_val16",  ival16,  m_val);
      end
      if ((m_r0 || m_r1) && !reset) begin
        chk("reg_addr",   raddr,   m_addr % NB);
        chk("reg_val",    rval,    m_val & 32'hFFFF);
        chk("reg_addr16", raddr16, m_addr % NB16);
        chk("reg_val16",  rval16,  m_val & 32'hFFFF);
      end
    end
  end

  // Holds the byte until an edge where the loader is ready; returns 1 time
  // unit after the accepting edge with in_valid still high.
  task automatic send(input logic [7:0] b);
    bit ok = 1'b0;
    bit rdy;
    in_valid = 1'b1;
    in_byte  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      ok = rdy;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL send_timeout byte %h: in_ready stayed 0, need 1", b);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_iwe", iwe, 0);
    chk("rst_r0", r0we, 0);
    chk("rst_r1", r1we, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_nbr", nbr, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_ival", ival, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_rval", rval, 0);
    idle(2);

    // instruction write, in_valid held high
    send(8'h01); send(8'h05); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    chk("s1_iwe", iwe, 1);
    chk("s1_iaddr", iaddr, 5);
    chk("s1_ival", ival, 32'hDEADBEEF);
    chk("s1_done", done, 1);
    chk("s1_ready", in_ready, 0);
    idle(3);

    // register-1 write with a 3-cycle stall before the last byte
    send(8'h03); send(8'h07); send(8'h12);
    idle(3);
    send(8'h34);
    chk("s2_r1", r1we, 1);
    chk("s2_r0", r0we, 0);
    chk("s2_raddr", raddr, 7);
    chk("s2_rval", rval, 16'h1234);
    idle(3);

    // set count, then halt
    send(8'h04); send(8'h03);
    chk("s3_nbr", nbr, 3);
    chk("s3_done1", done, 1);
    send(8'h05);
    chk("s3_nbr_halt", nbr, 0);
    chk("s3_done2", done, 1);
    idle(3);

    // partial frame discarded by reset
    send(8'h01); send(8'h02); send(8'hAA);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(8'h02); send(8'h09); send(8'hAB); send(8'hCD);
    chk("s5_r0", r0we, 1);
    chk("s5_iwe", iwe, 0);
    chk("s5_raddr", raddr, 9);
    chk("s5_rval", rval, 16'hABCD);
    chk("s5_nbr", nbr, 0);
    idle(3);

    // unknown opcode, then a normal frame
    send(8'h7F);
    chk("s4_err", err, 1);
    chk("s4_done", done, 0);
    send(8'h02); send(8'h00); send(8'h00); send(8'h01);
    chk("s4_r0", r0we, 1);
    chk("s4_raddr", raddr, 0);
    chk("s4_rval", rval, 16'h0001);
    idle(3);

    // reset landing on the WRITE cycle cancels the strobe
    send(8'h02); send(8'h01); send(8'h00); send(8'h05);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rw_r0", r0we, 0);
    chk("rw_done", done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3);

    // count saturation on the small instance
    send(8'h04); send(8'hFF);
    chk("sat_nbr16", nbr16, 15);
    chk("sat_nbr256", nbr, 255);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/block_loader.md
BLOCK_LOADER -- requirements
Module: block_loader

Interface
REQ-001 Parameter data_width, default 16, SHALL set the register value width; it must be a multiple of 8 and no more than 32.
REQ-002 Parameter n_blocks, default 256, SHALL set the block count; address width AW = $clog2(n_blocks), AW <= 8.
REQ-003 clk  input  1  clock; all state SHALL change only on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  command byte valid.
REQ-006 in_ready  output  1  loader accepts in_byte this cycle.
REQ-007 in_byte  input  8  command stream byte.
REQ-008 instr_write_addr  output  AW  instruction memory write address.
REQ-009 instr_write_val  output  32  instruction word.
REQ-010 instr_write_enable  output  1  one-cycle instruction write strobe.
REQ-011 reg_write_addr  output  AW  register memory write address.
REQ-012 reg_write_val  output  data_width  register value.
REQ-013 reg_0_write_enable  output  1  one-cycle register-0 write strobe.
REQ-014 reg_1_write_enable  output  1  one-cycle register-1 write strobe.
REQ-015 n_blocks_running  output  AW  count of active blocks driven to the fetch stage.
REQ-016 cmd_done  output  1  one-cycle pulse when a command completes.
REQ-017 cmd_error  output  1  one-cycle pulse when an opcode is unknown.

Function
REQ-018 A byte SHALL be accepted only when in_valid and in_ready are both high on a rising edge.
REQ-019 Opcodes SHALL be: 0x01 write instruction, 0x02 write register 0, 0x03 write register 1, 0x04 set n_blocks_running, 0x05 halt.
REQ-020 Frame formats SHALL be as follows.
- 0x01: opcode, addr byte, 4 instruction bytes, MSB first.
- 0x02/0x03: opcode, addr byte, data_width/8 value bytes, MSB first.
- 0x04: opcode, count byte.
- 0x05: opcode only.
REQ-021 The FSM SHALL have the states IDLE, ADDR, DATA, WRITE.
- IDLE: wait for an opcode byte.
- ADDR: capture the address or count byte.
- DATA: shift value bytes in and count them.
- WRITE: issue the strobe.
REQ-022 The address byte SHALL be truncated to its low AW bits.
REQ-023 in_ready SHALL be high in IDLE, ADDR and DATA, and low in WRITE.
REQ-024 After the last data byte of 0x01/0x02/0x03 is accepted, the FSM SHALL enter WRITE.
- In the WRITE cycle, exactly one matching strobe SHALL be high.
- The address/value outputs SHALL hold the assembled frame during that cycle.
- cmd_done SHALL pulse in the same cycle.
- The FSM SHALL then return to IDLE.
REQ-025 Write latency SHALL be one cycle: the strobe is high in the cycle after the final byte's accepting edge.
REQ-026 For 0x04, accepting the count byte SHALL update n_blocks_running on that edge.
- Values >= n_blocks saturate to n_blocks-1.
- cmd_done pulses the following cycle; the FSM returns to IDLE.
- No write strobe is issued.
REQ-027 For 0x05, accepting the opcode SHALL set n_blocks_running to 0 on that edge, and cmd_done SHALL pulse the following cycle.
REQ-028 Any other opcode SHALL be discarded, cmd_error SHALL pulse the following cycle, and the FSM SHALL remain in IDLE.
REQ-029 A byte-count register SHALL count DATA bytes from 0 and leave DATA when it reaches the frame length minus 1; it SHALL be cleared on entry to ADDR.
REQ-030 Strobes, cmd_done and cmd_error SHALL never be high for two consecutive cycles from a single command.
REQ-031 in_valid low mid-frame SHALL stall the FSM indefinitely with partial data preserved; there is no timeout.
REQ-032 Address and value outputs MAY change outside WRITE; consumers SHALL qualify them with the strobes only.

Reset
REQ-033 On reset, the FSM SHALL enter IDLE and any partial frame SHALL be discarded.
REQ-034 Reset values SHALL be:
- all strobes, cmd_done and cmd_error = 0
- n_blocks_running = 0
- instr_write_addr, reg_write_addr, instr_write_val, reg_write_val = 0
- byte counter = 0
REQ-035 Reset asserted during WRITE SHALL suppress that cycle's strobe.

Verification
REQ-036 The bench SHALL cover these scenarios.
- Stream 01 05 DE AD BE EF with in_valid held high: instr_write_enable high for exactly one cycle, one cycle after the byte EF is accepted, with addr=5 and val=0xDEADBEEF; cmd_done pulses in that cycle; in_ready is low that cycle.
- Stream 03 07 12 34 with in_valid deasserted for 3 cycles between 12 and 34: a single reg_1_write_enable pulse with addr=7 and val=0x1234; reg_0_write_enable stays 0.
- Stream 04 03, then 05: n_blocks_running = 3 after the count byte is accepted, then 0 after 05 is accepted; two cmd_done pulses; no strobes.
- Stream 7F then 02 00 00 01: a cmd_error pulse for 7F; the next frame produces reg_0_write_enable with addr=0 and val=1.
- Stream 01 02 AA, assert reset for one cycle, then 02 09 AB CD: no instruction write; reg_0 write with addr=9 and val=0xABCD; n_blocks_running = 0 throughout.
- With parameter n_blocks=16, stream 04 FF: n_blocks_running = 15.
